vcpu_exu: RTL

VCPU_EXU -- requirements
Module: vcpu_exu

---
 rtl/vcpu_pkg.sv | 37 +++
 rtl/vcpu_shifter.sv | 47 ++++
 rtl/vcpu_exu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vcpu_pkg.sv
// Shared definitions for the vcpu execution unit: opcodes, FSM states and the
// NZCV flag bundle.
package vcpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_RSB = 4'd4,
    OP_AND = 4'd5,
    OP_ORR = 4'd6,
    OP_EOR = 4'd7,
    OP_BIC = 4'd8,
    OP_LSL = 4'd9,
    OP_LSR = 4'd10,
    OP_ASR = 4'd11,
    OP_ROR = 4'd12,
    OP_MUL = 4'd13,
    OP_MOV = 4'd14,
    OP_MVN = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/vcpu_shifter.sv
// Combinational barrel shifter for LSL/LSR/ASR/ROR with ARM-style carry-out.
// A shift amount of zero passes the operand and the incoming carry unchanged.
module vcpu_shifter
  import vcpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] n,
  input  logic [7:0]       s,
  input  logic             cin,
  output logic [WIDTH-1:0] r,
  output logic             c
);

  localparam logic [7:0] W8 = 8'(WIDTH);

  logic [WIDTH:0]        lsl_t;
  logic [WIDTH:0]        lsr_t;
  logic signed [WIDTH:0] asr_t;
  logic [7:0]            k;
  logic [WIDTH-1:0]      ror_r;

  // The extra guard bit catches the last bit shifted out, so the carry needs
  // no variable indexing and over-long shifts fall out as zero naturally.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    lsl_t = {1'b0, n} << s;
    lsr_t = {n, 1'b0} >> s;
    asr_t = $signed({n, 1'b0}) >>> s;
    k     = s & (W8 - 8'd1);
    ror_r = (n >> k) | (n << (W8 - k));
    r     = n;
    c     = cin;
    if (s != 8'd0) begin
      case (op)
        OP_LSL: begin r = lsl_t[WIDTH-1:0]; c = lsl_t[WIDTH]; end
        OP_LSR: begin r = lsr_t[WIDTH:1];   c = lsr_t[0];     end
        OP_ASR: begin r = asr_t[WIDTH:1];   c = asr_t[0];     end
        OP_ROR: begin r = ror_r;            c = ror_r[WIDTH-1]; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vcpu_exu.sv
// vcpu execution unit: single-cycle ALU/shifter plus an iterative radix-2
// multiplier behind a valid/ready command interface with one output register.
module vcpu_exu
  import vcpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_n,
  input  logic [WIDTH-1:0] in_m,
  input  logic             in_cf,
  input  logic             in_vf,
  input  logic             in_setf,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic             out_nf,
  output logic             out_zf,
  output logic             out_cf,
  output logic             out_vf,
  output logic             out_setf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(WIDTH);

  state_e           state, state_nxt;
  op_e              op;
  logic             accept;
  logic             is_mul;

  logic [WIDTH-1:0] add_a, add_b;
  logic             add_ci;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sh_r;
  logic             sh_c;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_f;

  logic [WIDTH-1:0] acc, acc_nxt, mcand, mplier;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  flags_t           f_q;

  assign op        = op_e'(in_op);
  assign is_mul    = (op == OP_MUL);
  assign in_ready  = (state == ST_IDLE) || (state == ST_HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_HOLD);
  assign out_d     = d_q;
  assign out_nf    = f_q.n;
  assign out_zf    = f_q.z;
  assign out_cf    = f_q.c;
  assign out_vf    = f_q.v;

  vcpu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .op  (op),
    .n   (in_n),
    .s   (in_m[7:0]),
    .cin (in_cf),
    .r   (sh_r),
    .c   (sh_c)
  );

  // All add/subtract forms share one adder; only the addends and carry-in move.
  always_comb begin
    add_a  = in_n;
    add_b  = in_m;
    add_ci = 1'b0;
    case (op)
      OP_ADC: add_ci = in_cf;
      OP_SUB: begin add_b = ~in_m; add_ci = 1'b1; end
      OP_SBC: begin add_b = ~in_m; add_ci = in_cf; end
      OP_RSB: begin add_a = ~in_n; add_ci = 1'b1; end
      default: ;
    endcase
    sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
  end

  always_comb begin
    alu_res = in_m;
    alu_f.c = in_cf;
    alu_f.v = in_vf;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
        alu_res = sum[WIDTH-1:0];
        alu_f.c = sum[WIDTH];
        alu_f.v = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != add_a[WIDTH-1]);
      end
      OP_AND: alu_res = in_n & in_m;
      OP_ORR: alu_res = in_n | in_m;
      OP_EOR: alu_res = in_n ^ in_m;
      OP_BIC: alu_res = in_n & ~in_m;
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        alu_res = sh_r;
        alu_f.c = sh_c;
      end
      OP_MVN: alu_res = ~in_m;
      default: ;
    endcase
    alu_f.n = alu_res[WIDTH-1];
    alu_f.z = (alu_res == '0);
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_mul ? ST_MUL : ST_HOLD;
      ST_MUL:  if (cnt == '0) state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = accept ? (is_mul ? ST_MUL : ST_HOLD) : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Output fields only change on acceptance or multiply completion, which
  // keeps them stable while a result waits for out_ready.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      d_q      <= '0;
      f_q      <= '0;
      out_setf <= 1'b0;
      out_tag  <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else if (accept) begin
      out_setf <= in_setf;
      out_tag  <= in_tag;
      if (is_mul) begin
        acc    <= '0;
        mcand  <= in_n;
        mplier <= in_m;
        cnt    <= CW'(WIDTH - 1);
        f_q.c  <= in_cf;
        f_q.v  <= in_vf;
      end else begin
        d_q <= alu_res;
        f_q <= alu_f;
      end
    end else if (state == ST_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        d_q   <= acc_nxt;
        f_q.n <= acc_nxt[WIDTH-1];
        f_q.z <= (acc_nxt == '0);
      end
    end
  end

endmodule
